multdiv_iter: RTL and testbench

Iterative signed 32-bit multiply/divide unit for the execute stage, beside the combinational ALU (adder, shifters, logic). It takes two operands and a one-cycle start pulse, runs a 32-step shift-add multiply or restoring divide, and returns a 32-bit result with an exception flag and a one-cycle ready strobe. The pipeline stalls on `busy` and captures the result on `data_resultRDY`.

---
 rtl/multdiv_iter.sv | 159 +++++++++++++++
 tb/tb_multdiv_iter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply/divide unit.
// 32 shift-add multiply steps or 32 restoring divide steps per operation,
// with a one-cycle ready strobe and a registered result/exception pair.
module multdiv_iter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic        sign_q, sign_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;

    logic        start;
    logic [31:0] mag_a_in, mag_b_in;

    logic        mul_bit;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic        mul_neg;
    logic [31:0] mul_res;
    logic        mul_exc;

    logic [32:0] div_rem_sh;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic [31:0] div_res;
    logic        div_exc;

    assign start    = ctrl_MULT | ctrl_DIV;
    // Negating 0x80000000 yields 0x80000000, which is 2^31 read as unsigned.
    assign mag_a_in = data_operandA[31] ? -data_operandA : data_operandA;
    assign mag_b_in = data_operandB[31] ? -data_operandB : data_operandB;

    // Datapath for one multiply step and one divide step, plus final result shaping.
    always_comb begin
        // Multiply: acc high half accumulates, whole register shifts right with the carry.
        mul_bit  = mag_b_q[cnt_q];
        mul_sum  = {1'b0, acc_q[63:32]} + (mul_bit ? {1'b0, mag_a_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
        mul_neg  = sign_q & (|mul_next);
        mul_res  = mul_neg ? -mul_next[31:0] : mul_next[31:0];
        // A negative product may reach exactly 2^31 in magnitude without overflowing.
        mul_exc  = (|mul_next[63:31]) && !(mul_neg && (mul_next == 64'h0000_0000_8000_0000));

        // Divide: acc is remainder:quotient; dividend bits enter MSB first.
        div_rem_sh = {acc_q[63:32], mag_a_q[5'd31 - cnt_q]};
        div_diff   = {1'b0, div_rem_sh} - {2'b00, mag_b_q};
        if (!div_diff[33]) begin
            div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            div_next = {div_rem_sh[31:0], acc_q[30:0], 1'b0};
        end
        div_res = sign_q ? -div_next[31:0] : div_next[31:0];
        div_exc = 1'b0;
        if (mag_b_q == 32'd0) begin
            div_res = 32'd0;
            div_exc = 1'b1;
        end else if ((mag_a_q == 32'h8000_0000) && (mag_b_q == 32'd1) && !sign_q) begin
            // Only 0x80000000 / -1 produces a positive 2^31 quotient.
            div_exc = 1'b1;
        end
    end

    // Next-state and output register logic; a start overrides any running operation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        sign_d  = sign_q;
        res_d   = res_q;
        exc_d   = exc_q;
        rdy_d   = 1'b0;

        if (start) begin
            state_d = ctrl_MULT ? StMul : StDiv;
            cnt_d   = 5'd0;
            acc_d   = 64'd0;
            mag_a_d = mag_a_in;
            mag_b_d = mag_b_in;
            sign_d  = data_operandA[31] ^ data_operandB[31];
            exc_d   = 1'b0;
        end else begin
            unique case (state_q)
                StMul: begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StIdle;
                        res_d   = mul_res;
                        exc_d   = mul_exc;
                        rdy_d   = 1'b1;
                    end
                end
                StDiv: begin
                    acc_d = div_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StIdle;
                        res_d   = div_res;
                        exc_d   = div_exc;
                        rdy_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            mag_a_q <= 32'd0;
            mag_b_q <= 32'd0;
            sign_q  <= 1'b0;
            res_q   <= 32'd0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter: directed table, restart/reset sequences,
// and random signed operands checked through a scoreboard queue.
module tb_multdiv_iter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        cmul = 1'b0;
    logic        cdiv = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t scb[$];
    int   n_vec = 0;
    int   n_err = 0;

    multdiv_iter dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .ctrl_MULT      (cmul),
        .ctrl_DIV       (cdiv),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference using native signed arithmetic.
    function automatic exp_t model(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        exp_t               e;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] p;
        logic signed [31:0] q;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (!is_div) begin
            p     = sa * sb;
            e.res = p[31:0];
            e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            q     = $signed(a) / $signed(b);
            e.res = q;
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Drive a one-cycle start pulse; returns #1 after the start edge.
    task automatic start_op(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        opa  = a;
        opb  = b;
        cmul = !is_div;
        cdiv = is_div;
        @(posedge clock);
        #1;
        cmul = 1'b0;
        cdiv = 1'b0;
        opa  = $urandom;
        opb  = $urandom;
    endtask

    // Run one operation and check latency, busy profile, result and exception.
    task automatic do_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input bit check_drop, input string name);
        int   lat;
        bit   got;
        bit   busy_ok;
        exp_t p;
        start_op(is_div, a, b);
        scb.push_back(e);
        check({name, " start_rdy"}, {63'd0, data_resultRDY}, 64'd0);
        busy_ok = (busy === 1'b1);
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
            if (data_resultRDY === 1'b1) got = 1;
            else if (busy !== 1'b1) busy_ok = 0;
        end
        check({name, " latency"}, 64'(lat), 64'd32);
        check({name, " busy_profile"}, {63'd0, busy_ok}, 64'd1);
        if (got) begin
            check({name, " busy_at_rdy"}, {63'd0, busy}, 64'd0);
            if (scb.size() == 0) begin
                check({name, " scoreboard_empty"}, 64'd1, 64'd0);
            end else begin
                p = scb.pop_front();
                check({name, " result"}, {32'd0, data_result}, {32'd0, p.res});
                check({name, " exception"}, {63'd0, data_exception}, {63'd0, p.exc});
            end
        end else begin
            void'(scb.pop_back());
        end
        if (check_drop) begin
            @(posedge clock);
            #1;
            check({name, " rdy_drop"}, {62'd0, data_resultRDY, busy}, 64'd0);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        if ($urandom_range(0, 7) == 0) begin
            v = $urandom_range(0, 16) - 32'd8;
        end else begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
        end
        return v;
    endfunction

    vec_t vecs[9];

    initial begin
        exp_t        e;
        bit          saw_rdy;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[2] = '{1'b0, 32'h8000_0000,  32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0000, 32'h8000_0000, 1'b1};
        vecs[4] = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
        vecs[5] = '{1'b1, 32'd100,        32'd0,         32'h0000_0000, 1'b1};
        vecs[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[7] = '{1'b1, 32'd1000,       32'd10,        32'd100,       1'b0};
        vecs[8] = '{1'b0, 32'd0,          32'hFFFF_FFFB, 32'd0,         1'b0};

        // Reset state.
        #1;
        check("reset_outputs", {data_result, 29'd0, data_exception, data_resultRDY, busy}, 64'd0);
        repeat (3) @(posedge clock);
        #1;
        check("reset_held", {data_result, 29'd0, data_exception, data_resultRDY, busy}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("idle_outputs", {data_result, 29'd0, data_exception, data_resultRDY, busy}, 64'd0);

        // Directed table; odd entries start back-to-back on the ready cycle.
        for (int i = 0; i < 9; i++) begin
            e.res = vecs[i].res;
            e.exc = vecs[i].exc;
            do_op(vecs[i].is_div, vecs[i].a, vecs[i].b, e, (i % 2) == 0,
                  $sformatf("vec%0d", i));
        end

        // Restart: DIV abandoned by a MULT ten cycles later.
        start_op(1'b1, 32'd1000, 32'd10);
        saw_rdy = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) saw_rdy = 1;
        end
        check("restart_no_early_rdy", {63'd0, saw_rdy}, 64'd0);
        e.res = 32'h0000_001E;
        e.exc = 1'b0;
        do_op(1'b0, 32'd6, 32'd5, e, 1'b1, "restart_mul");
        saw_rdy = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) saw_rdy = 1;
        end
        check("restart_single_rdy", {63'd0, saw_rdy}, 64'd0);

        // Reset mid-operation.
        start_op(1'b0, 32'd12345, 32'd678);
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", {data_result, 29'd0, data_exception, data_resultRDY, busy}, 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        saw_rdy = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1 || busy === 1'b1) saw_rdy = 1;
        end
        check("midreset_no_rdy", {63'd0, saw_rdy}, 64'd0);
        check("midreset_after", {data_result, 30'd0, data_exception, data_resultRDY}, 64'd0);

        // Random signed operands, alternating ops, some back-to-back.
        for (int i = 0; i < 2000; i++) begin
            d = (i % 2) == 1;
            a = rand_operand();
            b = rand_operand();
            e = model(d, a, b);
            do_op(d, a, b, e, (i % 5) == 0, $sformatf("rnd%0d %s %h %h", i, d ? "div" : "mul", a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
